// File: rtl/instr_mem_if.sv
// Instruction memory bus interface.
// Groups the program-load stream, the fetch port and the status outputs of
// instr_mem. The slave modport is the memory side; master is the driver side
// (CPU / loader / testbench).
//   load_en, load_valid, load_data  -> load request, beat valid, word
//   load_ready, load_done, load_count <- load flow control and completion
//   fetch_req, fetch_addr           -> fetch request and byte address
//   instruction, instr_valid        <- registered fetch result
//   fault_misalign, fault_range     <- fetch fault flags (with instr_valid)
//   busy                            <- memory not in RUN
interface instr_mem_if #(
  parameter int unsigned DEPTH_WORDS = 64
);
  localparam int unsigned CNT_W = $clog2(DEPTH_WORDS) + 1;

  logic             load_en;
  logic             load_valid;
  logic [31:0]      load_data;
  logic             load_ready;
  logic             load_done;
  logic [CNT_W-1:0] load_count;
  logic             fetch_req;
  logic [31:0]      fetch_addr;
  logic [31:0]      instruction;
  logic             instr_valid;
  logic             fault_misalign;
  logic             fault_range;
  logic             busy;

  modport slave (
    input  load_en, load_valid, load_data, fetch_req, fetch_addr,
    output load_ready, load_done, load_count, instruction, instr_valid,
           fault_misalign, fault_range, busy
  );

  modport master (
    output load_en, load_valid, load_data, fetch_req, fetch_addr,
    input  load_ready, load_done, load_count, instruction, instr_valid,
           fault_misalign, fault_range, busy
  );
endinterface

// File: rtl/instr_mem.sv
// Instruction memory with program-load and fetch ports.
// After reset the array is filled with NOP_WORD (one word per cycle), then
// the block serves 1-cycle-latency fetches in RUN. A level load_en switches
// to LOAD, where a valid/ready stream writes words from index 0 upward,
// saturating at DEPTH_WORDS. Leaving LOAD pulses load_done and latches the
// number of words written into load_count.
// Ports:
//   clk    - single clock, rising edge
//   rst_n  - asynchronous active-low reset
//   bus    - instr_mem_if slave modport (load, fetch and status signals)
module instr_mem #(
  parameter int unsigned DEPTH_WORDS = 64,
  parameter logic [31:0] NOP_WORD    = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  instr_mem_if.slave  bus
);

  localparam int unsigned AW = $clog2(DEPTH_WORDS);
  localparam int unsigned CW = AW + 1;

  typedef enum logic [1:0] {
    ST_CLEAR,
    ST_RUN,
    ST_LOAD
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] ptr_q, ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          done_q, done_d;
  logic [31:0]   instr_q, instr_d;
  logic          valid_q, valid_d;
  logic          fm_q, fm_d;
  logic          fr_q, fr_d;

  logic [31:0]   mem_q [DEPTH_WORDS];

  logic          we;
  logic [AW-1:0] waddr;
  logic [31:0]   wdata;

  logic          ready;
  logic          beat;
  logic          misalign;
  logic          out_range;
  logic [AW-1:0] raddr;

  // ptr never exceeds DEPTH_WORDS, so its top bit alone marks "full".
  assign ready     = (state_q == ST_LOAD) && !ptr_q[AW];
  assign beat      = ready && bus.load_valid;
  assign misalign  = |bus.fetch_addr[1:0];
  assign out_range = |bus.fetch_addr[31:AW+2];
  assign raddr     = bus.fetch_addr[AW+1:2];

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    count_d = count_q;
    done_d  = 1'b0;
    instr_d = instr_q;
    valid_d = 1'b0;
    fm_d    = 1'b0;
    fr_d    = 1'b0;
    we      = 1'b0;
    waddr   = ptr_q[AW-1:0];
    wdata   = NOP_WORD;

    unique case (state_q)
      ST_CLEAR: begin
        // The pointer doubles as the clear address; load_en only matters
        // on the final clear cycle, where it steers straight into LOAD.
        we = 1'b1;
        if (ptr_q == CW'(DEPTH_WORDS - 1)) begin
          ptr_d   = '0;
          state_d = bus.load_en ? ST_LOAD : ST_RUN;
        end else begin
          ptr_d = ptr_q + 1'b1;
        end
      end

      ST_RUN: begin
        if (bus.fetch_req) begin
          valid_d = 1'b1;
          fm_d    = misalign;
          fr_d    = out_range;
          instr_d = (misalign || out_range) ? NOP_WORD : mem_q[raddr];
        end
        if (bus.load_en) begin
          state_d = ST_LOAD;
          ptr_d   = '0;
        end
      end

      ST_LOAD: begin
        if (beat) begin
          we    = 1'b1;
          wdata = bus.load_data;
          ptr_d = ptr_q + 1'b1;
        end
        // count includes a beat accepted on the exit cycle
        if (!bus.load_en) begin
          state_d = ST_RUN;
          done_d  = 1'b1;
          count_d = ptr_d;
        end
      end

      default: state_d = ST_CLEAR;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_CLEAR;
      ptr_q   <= '0;
      count_q <= '0;
      done_q  <= 1'b0;
      instr_q <= NOP_WORD;
      valid_q <= 1'b0;
      fm_q    <= 1'b0;
      fr_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      count_q <= count_d;
      done_q  <= done_d;
      instr_q <= instr_d;
      valid_q <= valid_d;
      fm_q    <= fm_d;
      fr_q    <= fr_d;
    end
  end

  // Storage has no reset: the CLEAR sweep after every reset initialises it.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign bus.load_ready     = ready;
  assign bus.load_done      = done_q;
  assign bus.load_count     = count_q;
  assign bus.instruction    = instr_q;
  assign bus.instr_valid    = valid_q;
  assign bus.fault_misalign = fm_q;
  assign bus.fault_range    = fr_q;
  assign bus.busy           = (state_q != ST_RUN);

endmodule

// File: tb/tb_instr_mem.sv
// Testbench for instr_mem: directed load/fetch/reset sequences, a
// behavioural model checked against the DUT every cycle, and literal
// expectations at key points.
module tb_instr_mem;

  localparam int unsigned DEPTH = 64;
  localparam logic [31:0] NOP   = 32'h0000_0000;

  localparam int M_CLR = 0;
  localparam int M_RUN = 1;
  localparam int M_LD  = 2;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  instr_mem_if #(.DEPTH_WORDS(DEPTH)) bus ();

  instr_mem #(.DEPTH_WORDS(DEPTH), .NOP_WORD(NOP)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [31:0] m_mem [DEPTH];
  int          m_mode  = M_CLR;
  int          m_clear = 0;
  int          m_lptr  = 0;
  int          m_count = 0;
  logic        m_valid = 1'b0;
  logic        m_fm    = 1'b0;
  logic        m_fr    = 1'b0;
  logic        m_done  = 1'b0;
  logic [31:0] m_instr = NOP;
  logic [31:0] m_addr;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_mode  = M_CLR;
      m_clear = 0;
      m_lptr  = 0;
      m_count = 0;
      m_valid = 1'b0;
      m_fm    = 1'b0;
      m_fr    = 1'b0;
      m_done  = 1'b0;
      m_instr = NOP;
    end else begin
      m_done  = 1'b0;
      m_valid = 1'b0;
      m_fm    = 1'b0;
      m_fr    = 1'b0;
      case (m_mode)
        M_CLR: begin
          m_clear++;
          if (m_clear == DEPTH) begin
            for (int i = 0; i < DEPTH; i++) m_mem[i] = NOP;
            m_mode = bus.load_en ? M_LD : M_RUN;
            m_lptr = 0;
          end
        end
        M_RUN: begin
          if (bus.fetch_req) begin
            m_addr  = bus.fetch_addr;
            m_valid = 1'b1;
            m_fm    = (m_addr % 4) != 0;
            m_fr    = (m_addr / 4) >= DEPTH;
            m_instr = (m_fm || m_fr) ? NOP : m_mem[m_addr / 4];
          end
          if (bus.load_en) begin
            m_mode = M_LD;
            m_lptr = 0;
          end
        end
        default: begin
          if (bus.load_valid && m_lptr < DEPTH) begin
            m_mem[m_lptr] = bus.load_data;
            m_lptr++;
          end
          if (!bus.load_en) begin
            m_mode  = M_RUN;
            m_done  = 1'b1;
            m_count = m_lptr;
          end
        end
      endcase
    end
  end

  always @(negedge clk) begin
    check("busy",           32'(bus.busy),           32'(m_mode != M_RUN));
    check("load_ready",     32'(bus.load_ready),     32'(m_mode == M_LD && m_lptr < DEPTH));
    check("load_done",      32'(bus.load_done),      32'(m_done));
    check("load_count",     32'(bus.load_count),     32'(m_count));
    check("instr_valid",    32'(bus.instr_valid),    32'(m_valid));
    check("fault_misalign", 32'(bus.fault_misalign), 32'(m_fm));
    check("fault_range",    32'(bus.fault_range),    32'(m_fr));
    check("instruction",    bus.instruction,         m_instr);
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fetch(input logic [31:0] addr, input logic [31:0] exp,
                       input logic efm, input logic efr);
    bus.fetch_req  = 1'b1;
    bus.fetch_addr = addr;
    tick();
    bus.fetch_req  = 1'b0;
    check("lit_valid", 32'(bus.instr_valid), 32'd1);
    check("lit_instr", bus.instruction, exp);
    check("lit_fm",    32'(bus.fault_misalign), 32'(efm));
    check("lit_fr",    32'(bus.fault_range),    32'(efr));
  endtask

  task automatic wait_clear(input string name);
    int n = 0;
    while (bus.busy && n < 200) begin
      tick();
      n++;
    end
    check(name, 32'(n), 32'(DEPTH));
  endtask

  logic [31:0] ldq [$];

  task automatic do_load();
    bus.load_en = 1'b1;
    tick();
    check("lit_ready_on_entry", 32'(bus.load_ready), 32'd1);
    foreach (ldq[i]) begin
      bus.load_valid = 1'b1;
      bus.load_data  = ldq[i];
      tick();
      if (i == DEPTH - 1)
        check("lit_ready_full", 32'(bus.load_ready), 32'd0);
    end
    bus.load_valid = 1'b0;
    bus.load_en    = 1'b0;
    tick();
    check("lit_done_pulse", 32'(bus.load_done), 32'd1);
    check("lit_count", 32'(bus.load_count), 32'(ldq.size() > DEPTH ? DEPTH : ldq.size()));
    tick();
    check("lit_done_low", 32'(bus.load_done), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n          = 1'b0;
    bus.load_en    = 1'b0;
    bus.load_valid = 1'b0;
    bus.load_data  = '0;
    bus.fetch_req  = 1'b0;
    bus.fetch_addr = '0;
    #1;
    check("rst_busy",  32'(bus.busy),        32'd1);
    check("rst_valid", 32'(bus.instr_valid), 32'd0);
    check("rst_ready", 32'(bus.load_ready),  32'd0);
    check("rst_instr", bus.instruction,      NOP);
    #11;
    rst_n = 1'b1;
    wait_clear("clear_cycles");

    fetch(32'h00, NOP, 1'b0, 1'b0);

    ldq = '{32'h201d00fc, 32'hafbe0000, 32'h23bdfffc};
    do_load();
    fetch(32'h04, 32'hafbe0000, 1'b0, 1'b0);
    fetch(32'h0C, NOP, 1'b0, 1'b0);

    fetch(32'h06,  NOP, 1'b1, 1'b0);
    fetch(32'h100, NOP, 1'b0, 1'b1);
    fetch(32'h102, NOP, 1'b1, 1'b1);

    // back-to-back fetches
    bus.fetch_req  = 1'b1;
    bus.fetch_addr = 32'h00;
    tick();
    check("b2b0_valid", 32'(bus.instr_valid), 32'd1);
    check("b2b0_instr", bus.instruction, 32'h201d00fc);
    bus.fetch_addr = 32'h04;
    tick();
    check("b2b1_valid", 32'(bus.instr_valid), 32'd1);
    check("b2b1_instr", bus.instruction, 32'hafbe0000);
    bus.fetch_addr = 32'h08;
    tick();
    bus.fetch_req = 1'b0;
    check("b2b2_valid", 32'(bus.instr_valid), 32'd1);
    check("b2b2_instr", bus.instruction, 32'h23bdfffc);
    tick();
    check("b2b_idle", 32'(bus.instr_valid), 32'd0);

    // overflow load: 70 words into 64
    ldq.delete();
    for (int i = 0; i < 70; i++) ldq.push_back(32'hA000_0000 + 32'(i));
    do_load();
    fetch(32'hFC, 32'hA000_003F, 1'b0, 1'b0);
    fetch(32'h00, 32'hA000_0000, 1'b0, 1'b0);

    // partial load keeps untouched words
    ldq = '{32'hB000_0000, 32'hB000_0001};
    do_load();
    fetch(32'h08, 32'hA000_0002, 1'b0, 1'b0);
    fetch(32'h04, 32'hB000_0001, 1'b0, 1'b0);

    // reset in the middle of a load
    bus.load_en = 1'b1;
    tick();
    for (int i = 0; i < 5; i++) begin
      bus.load_valid = 1'b1;
      bus.load_data  = 32'hC000_0000 + 32'(i);
      tick();
    end
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_busy",  32'(bus.busy),        32'd1);
    check("mid_rst_ready", 32'(bus.load_ready),  32'd0);
    check("mid_rst_valid", 32'(bus.instr_valid), 32'd0);
    check("mid_rst_done",  32'(bus.load_done),   32'd0);
    check("mid_rst_count", 32'(bus.load_count),  32'd0);
    check("mid_rst_instr", bus.instruction,      NOP);
    bus.load_en    = 1'b0;
    bus.load_valid = 1'b0;
    tick();
    tick();
    @(negedge clk);
    #1;
    rst_n = 1'b1;
    wait_clear("reclear_cycles");
    fetch(32'h00, NOP, 1'b0, 1'b0);
    fetch(32'h04, NOP, 1'b0, 1'b0);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/instr_mem.md
INSTR_MEM -- requirements
Module: instr_mem

Interface
REQ-001 The block SHALL have parameter DEPTH_WORDS, default 64, giving the number of 32-bit instruction words stored (power of two, 4..4096).
REQ-002 The block SHALL have parameter NOP_WORD, default 32'h00000000, giving the fill and fault return value.
REQ-003 The block SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 The block SHALL have port load_en  input  1  level request to enter/stay in program-load mode.
REQ-006 The block SHALL have port load_valid  input  1  load word present on load_data.
REQ-007 The block SHALL have port load_data  input  32  instruction word to store.
REQ-008 The block SHALL have port load_ready  output  1  block accepts load word this cycle.
REQ-009 The block SHALL have port load_done  output  1  one-cycle pulse on load completion.
REQ-010 The block SHALL have port load_count  output  log2(DEPTH_WORDS)+1  words written in last load.
REQ-011 The block SHALL have port fetch_req  input  1  fetch request.
REQ-012 The block SHALL have port fetch_addr  input  32  byte address of the fetch.
REQ-013 The block SHALL have port instruction  output  32  registered fetch result.
REQ-014 The block SHALL have port instr_valid  output  1  instruction valid this cycle.
REQ-015 The block SHALL have port fault_misalign  output  1  fetch_addr[1:0] nonzero, qualified by instr_valid.
REQ-016 The block SHALL have port fault_range  output  1  word index >= DEPTH_WORDS, qualified by instr_valid.
REQ-017 The block SHALL have port busy  output  1  state is not RUN.

Function
REQ-018 The FSM SHALL have states CLEAR, RUN and LOAD.
REQ-019 After reset the FSM SHALL be in CLEAR and write NOP_WORD to words 0..DEPTH_WORDS-1, one word per cycle, then enter RUN; CLEAR SHALL take exactly DEPTH_WORDS cycles.
REQ-020 In CLEAR, load_en SHALL be ignored; a LOAD request pending at the end of CLEAR SHALL enter LOAD on the next cycle.
REQ-021 RUN->LOAD SHALL occur on the cycle after load_en is sampled high; on entry the write pointer SHALL clear to 0.
REQ-022 load_ready SHALL be 1 only in LOAD while pointer < DEPTH_WORDS.
REQ-023 Each cycle with load_valid & load_ready SHALL write load_data at word[pointer] and increment the pointer.
REQ-024 When the pointer equals DEPTH_WORDS, load_ready SHALL drop to 0 and further words SHALL be dropped without wrap-around.
REQ-025 LOAD->RUN SHALL occur on the cycle after load_en is sampled low; a beat with load_valid & load_ready in that cycle SHALL still be written.
REQ-026 On the LOAD->RUN transition, load_done SHALL pulse for one cycle and load_count SHALL latch the pointer.
REQ-027 Words not written during a load SHALL keep their prior contents.
REQ-028 In RUN, fetch_req high at edge N SHALL produce instruction and instr_valid=1 after edge N+1 (1-cycle latency), at a throughput of one fetch per cycle.
REQ-029 instruction SHALL equal word[fetch_addr>>2], with byte at address a on bits [7:0] and byte a+3 on [31:24] (little-endian).
REQ-030 A misaligned fetch SHALL return NOP_WORD and assert fault_misalign.
REQ-031 An out-of-range fetch SHALL return NOP_WORD and assert fault_range.
REQ-032 When a fetch is both misaligned and out of range, both faults SHALL be asserted.
REQ-033 fetch_req in CLEAR or LOAD SHALL be dropped (instr_valid=0); instruction SHALL hold its last value.
REQ-034 Fault flags and instr_valid SHALL be 0 whenever no valid fetch was accepted in the previous cycle.

Reset
REQ-035 Asserting rst_n low SHALL immediately force state=CLEAR, clear pointer/count, and set instruction=NOP_WORD, instr_valid=0, faults=0, load_ready=0, load_done=0, busy=1.
REQ-036 Reset mid-LOAD SHALL abandon the load and re-clear all memory to NOP_WORD.
REQ-037 Release of rst_n SHALL start CLEAR at the first rising edge after release.

Verification
REQ-038 Reset, then wait DEPTH_WORDS=64 cycles -> busy falls on cycle 64; fetch 0x00 -> 0x00000000, instr_valid=1 one cycle later.
REQ-039 Load 0x201d00fc, 0xafbe0000, 0x23bdfffc, then drop load_en -> load_done pulse, load_count=3; fetch 0x04 -> 0xafbe0000; fetch 0x0C -> NOP_WORD.
REQ-040 Fetch 0x06 -> NOP_WORD, fault_misalign=1; fetch 0x100 (DEPTH 64) -> NOP_WORD, fault_range=1; fetch 0x102 -> both faults.
REQ-041 Load 70 words into DEPTH 64 -> load_ready=0 after 64 beats; load_count=64; word 63 holds the 64th value.
REQ-042 Back-to-back fetches 0x00,0x04,0x08 on consecutive cycles -> three consecutive valid words, no bubbles.
REQ-043 Assert rst_n low mid-load after 5 words -> outputs take reset values immediately; after CLEAR, fetch 0x00 -> NOP_WORD.
